// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port data memory.
// Each access runs IDLE -> ACCESS -> RESP, giving one access every three cycles.
module dmem_arbiter #(
  parameter int unsigned WL = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [WL-1:0] c_addr,
  input  logic [WL-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [WL-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [WL-1:0] d_addr,
  input  logic [WL-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [WL-1:0] d_rdata,
  output logic          mem_we,
  output logic [WL-1:0] mem_addr,
  output logic [WL-1:0] mem_wdata,
  input  logic [WL-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;     // 0 favours C, 1 favours D
  logic          id_q, id_d;         // latched winner: 0 = C, 1 = D
  logic          we_q, we_d;
  logic [WL-1:0] addr_q, addr_d;
  logic [WL-1:0] wdata_q, wdata_d;
  logic          c_gnt_q, c_gnt_d;
  logic          d_gnt_q, d_gnt_d;
  logic          c_rvalid_q, c_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [WL-1:0] c_rdata_q, c_rdata_d;
  logic [WL-1:0] d_rdata_q, d_rdata_d;
  logic          mem_we_q, mem_we_d;
  logic          busy_q, busy_d;
  logic          win_d;

  // Next-state, command latching and response capture.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    id_d       = id_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    c_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    c_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    c_rdata_d  = c_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_we_d   = 1'b0;
    win_d      = ~(c_req & (~d_req | ~prio_q));

    unique case (state_q)
      IDLE: begin
        if (c_req | d_req) begin
          id_d     = win_d;
          we_d     = win_d ? d_we    : c_we;
          addr_d   = win_d ? d_addr  : c_addr;
          wdata_d  = win_d ? d_wdata : c_wdata;
          c_gnt_d  = ~win_d;
          d_gnt_d  = win_d;
          prio_d   = ~win_d;
          mem_we_d = win_d ? d_we : c_we;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        // Capture for reads and writes alike; only the winner's register moves.
        if (id_q) begin
          d_rdata_d  = mem_rdata;
          d_rvalid_d = 1'b1;
        end else begin
          c_rdata_d  = mem_rdata;
          c_rvalid_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      c_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      id_q       <= id_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      c_gnt_q    <= c_gnt_d;
      d_gnt_q    <= d_gnt_d;
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
    end
  end

  assign c_gnt     = c_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign c_rvalid  = c_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign c_rdata   = c_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model (pending requests, round-robin
// pointer, word memory) predicts grants, responses and read data per access.
module tb_dmem_arbiter;
  localparam int unsigned WL = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          c_req, c_we, d_req, d_we;
  logic [WL-1:0] c_addr, c_wdata, d_addr, d_wdata;
  logic          c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [WL-1:0] c_rdata, d_rdata;
  logic          mem_we;
  logic [WL-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          busy;

  dmem_arbiter #(.WL(WL)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment memory: combinational read, write on rising edge, 16 words.
  logic [WL-1:0] mem [16];
  assign mem_rdata = mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [WL-1:0] ref_mem [16];
  bit            pend [2];
  bit            pulse [2];
  logic          p_we [2];
  logic [WL-1:0] p_addr [2];
  logic [WL-1:0] p_wd [2];
  logic [WL-1:0] exp_rdata [2];
  int            prio_m;
  int            last_w;
  bit            rnd;

  task automatic chk(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_pins();
    c_req = pend[0] | pulse[0]; c_we = p_we[0]; c_addr = p_addr[0]; c_wdata = p_wd[0];
    d_req = pend[1] | pulse[1]; d_we = p_we[1]; d_addr = p_addr[1]; d_wdata = p_wd[1];
  endtask

  task automatic set_req(input int p, input logic we, input logic [WL-1:0] a, input logic [WL-1:0] wd);
    pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wd[p] = wd;
  endtask

  task automatic rand_fields(input int p);
    p_we[p] = 1'($urandom_range(0, 1));
    p_addr[p] = $urandom & 32'hF000_000F;
    p_wd[p] = $urandom;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_c_gnt"}, {31'd0, c_gnt}, 0);
    chk({tag, "_d_gnt"}, {31'd0, d_gnt}, 0);
    chk({tag, "_c_rvalid"}, {31'd0, c_rvalid}, 0);
    chk({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 0);
    chk({tag, "_c_rdata"}, c_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  // One arbitration opportunity, entered at the falling edge of an IDLE cycle.
  task automatic run_round();
    int w;
    logic [WL-1:0] old;
    logic [WL-1:0] a;
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_gnt", {30'd0, c_gnt, d_gnt}, 0);
    chk("idle_rvalid", {30'd0, c_rvalid, d_rvalid}, 0);
    chk("idle_mem_we", {31'd0, mem_we}, 0);
    chk("idle_c_rdata", c_rdata, exp_rdata[0]);
    chk("idle_d_rdata", d_rdata, exp_rdata[1]);
    if (rnd)
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          rand_fields(p);
          pend[p] = 1'b1;
        end
    drive_pins();
    if (!pend[0] && !pend[1]) begin
      last_w = -1;
      @(negedge clk);
      return;
    end
    w = (pend[0] && (!pend[1] || prio_m == 0)) ? 0 : 1;
    prio_m = 1 - w;
    last_w = w;
    a = p_addr[w];
    @(negedge clk);  // ACCESS
    chk("acc_c_gnt", {31'd0, c_gnt}, {31'd0, w == 0});
    chk("acc_d_gnt", {31'd0, d_gnt}, {31'd0, w == 1});
    chk("acc_rvalid", {30'd0, c_rvalid, d_rvalid}, 0);
    chk("acc_busy", {31'd0, busy}, 1);
    chk("acc_mem_we", {31'd0, mem_we}, {31'd0, p_we[w]});
    chk("acc_mem_addr", mem_addr, a);
    if (p_we[w]) chk("acc_mem_wdata", mem_wdata, p_wd[w]);
    old = ref_mem[a[3:0]];
    exp_rdata[w] = old;
    if (p_we[w]) ref_mem[a[3:0]] = p_wd[w];
    pend[w] = 1'b0;
    // Short request pulses while busy must never be serviced.
    for (int p = 0; p < 2; p++)
      if (!pend[p] && $urandom_range(0, 3) == 0) begin
        rand_fields(p);
        pulse[p] = 1'b1;
      end
    drive_pins();
    @(negedge clk);  // RESP
    pulse[0] = 1'b0; pulse[1] = 1'b0;
    drive_pins();
    chk("resp_c_rvalid", {31'd0, c_rvalid}, {31'd0, w == 0});
    chk("resp_d_rvalid", {31'd0, d_rvalid}, {31'd0, w == 1});
    chk("resp_gnt", {30'd0, c_gnt, d_gnt}, 0);
    chk("resp_mem_we", {31'd0, mem_we}, 0);
    chk("resp_busy", {31'd0, busy}, 1);
    chk("resp_mem_addr", mem_addr, a);
    chk("resp_c_rdata", c_rdata, exp_rdata[0]);
    chk("resp_d_rdata", d_rdata, exp_rdata[1]);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; pulse[p] = 1'b0; p_we[p] = 1'b0;
      p_addr[p] = '0; p_wd[p] = '0; exp_rdata[p] = '0;
    end
    prio_m = 0;
    last_w = -1;
    rnd = 1'b0;
    rst_n = 1'b0;

    // Reset with both requesting, then contention: C, D, C, D.
    set_req(0, 1'b0, 32'd3, 32'h0);
    set_req(1, 1'b0, 32'd7, 32'h0);
    drive_pins();
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!pend[0]) set_req(0, 1'b1, 32'(i), 32'h1000 + 32'(i));
      if (!pend[1]) set_req(1, 1'b0, 32'(i + 8), 32'h0);
      run_round();
      chk("contend_order", 32'(last_w), 32'(i % 2));
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    run_round();  // loser leftover dropped: idle round

    // Single C write then read of address 5.
    set_req(0, 1'b1, 32'd5, 32'hDEADBEEF);
    run_round();
    set_req(0, 1'b0, 32'd5, 32'h0);
    run_round();
    chk("c_read5", c_rdata, 32'hDEADBEEF);

    // Fairness: D alone, then both -> C first (twice).
    for (int k = 0; k < 2; k++) begin
      set_req(1, 1'b0, 32'd5, 32'h0);
      run_round();
      set_req(0, 1'b0, 32'd1, 32'h0);
      set_req(1, 1'b1, 32'd2, 32'hABCD0000 + 32'(k));
      run_round();
      chk("fair_c_first", 32'(last_w), 32'd0);
      run_round();
    end

    // Async reset during a D read in ACCESS.
    set_req(1, 1'b0, 32'd5, 32'h0);
    drive_pins();
    @(negedge clk);
    chk("rst_mid_d_gnt", {31'd0, d_gnt}, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_pins();
    @(negedge clk);
    chk("rst_mid_no_rvalid", {31'd0, d_rvalid}, 0);
    rst_n = 1'b1;
    prio_m = 0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    set_req(0, 1'b0, 32'd0, 32'h0);
    run_round();
    chk("post_rst_c_rvalid_seen", 32'(last_w), 32'd0);

    // Randomized traffic including idle-gap pulses.
    rnd = 1'b1;
    for (int i = 0; i < 300; i++) run_round();
    rnd = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_pins();
    run_round();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
